// File: rtl/ucode_pkg.sv
// Shared microword layout, sequencer op encodings and control-store geometry
// for the microcode fetch stage.
package ucode_pkg;

  localparam int UCODE_DEPTH = 4096;
  localparam int UCODE_WIDTH = 48;
  localparam int ADDR_W      = 12;
  localparam int COND_W      = 7;

  localparam int PAR_BIT  = 47;
  localparam int OP_LSB   = 45;
  localparam int OP_W     = 2;
  localparam int CSEL_LSB = 42;
  localparam int CSEL_W   = 3;
  localparam int CINV_BIT = 41;
  localparam int OFFS_LSB = 29;
  localparam int OFFS_W   = 12;
  localparam int CTRL_LSB = 0;
  localparam int CTRL_W   = 29;

  typedef enum logic [OP_W-1:0] {
    OP_NEXT   = 2'd0,
    OP_JUMP   = 2'd1,
    OP_CALL   = 2'd2,
    OP_RETURN = 2'd3
  } seq_op_e;

  typedef struct packed {
    logic              parity;
    seq_op_e           op;
    logic [CSEL_W-1:0] csel;
    logic              cinv;
    logic [OFFS_W-1:0] offset;
    logic [CTRL_W-1:0] ctrl;
  } uword_t;

  // csel 0 is the unconditional test; csel k selects cond[k-1].
  function automatic logic cond_test(input logic [CSEL_W-1:0] csel,
                                     input logic              cinv,
                                     input logic [COND_W-1:0] cond);
    logic sel;
    sel = (csel == '0) ? 1'b1 : cond[csel - 3'd1];
    return sel ^ cinv;
  endfunction

endpackage

// File: rtl/ucode_ram.sv
// Control store: one write port plus one read-first registered read port whose
// output register doubles as the MIR (cleared by reset, contents never are).
module ucode_ram
  import ucode_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rd_en,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [UCODE_WIDTH-1:0] rd_data,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [UCODE_WIDTH-1:0] wr_data
);

  logic [UCODE_WIDTH-1:0] mem [UCODE_DEPTH];
  logic [UCODE_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Nonblocking read of mem gives read-first behaviour on a same-address write.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/microcode_fetch.sv
// Microcode fetch stage: control store + MIR, condition test and sequencer op
// steering. Optional parity checking/halt is enabled by the macro UCODE_PARITY_EN.
module microcode_fetch
  import ucode_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [COND_W-1:0]      cond,
  input  logic                   stall,
  input  logic                   load_en,
  input  logic [ADDR_W-1:0]      load_addr,
  input  logic [UCODE_WIDTH-1:0] load_data,
  output logic [OP_W-1:0]        seq_op,
  output logic [OFFS_W-1:0]      seq_din,
  output logic                   seq_active,
  output logic [CTRL_W-1:0]      ctrl,
  output logic                   ctrl_valid,
  output logic [ADDR_W-1:0]      uaddr_q,
  output logic                   perr
);

  logic [UCODE_WIDTH-1:0] mir_raw;
  uword_t                 mir;
  logic                   run;
  logic                   halt;
  logic [ADDR_W-1:0]      uaddr_d;
  logic                   ctrl_valid_q;
  logic                   ctrl_valid_d;

  // Reset blocks the write so a load coinciding with reset is dropped.
  ucode_ram u_ram (
    .clock   (clock),
    .reset   (reset),
    .rd_en   (run),
    .rd_addr (addr),
    .rd_data (mir_raw),
    .wr_en   (load_en && !reset),
    .wr_addr (load_addr),
    .wr_data (load_data)
  );

  assign mir = uword_t'(mir_raw);
  assign run = !stall && !halt;

`ifdef UCODE_PARITY_EN
  logic par_err;
  logic halt_q, halt_d;
  logic perr_q, perr_d;

  // A bad word is flagged in the same cycle it lands in the MIR, so it never issues.
  assign par_err = ^mir_raw;
  assign halt    = halt_q | par_err;
  assign perr    = perr_q | par_err;

  always_comb begin
    halt_d = halt;
    perr_d = perr_q | par_err;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      halt_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
      perr_q <= perr_d;
    end
  end
`else
  logic unused_parity;

  assign unused_parity = mir.parity;
  assign halt          = 1'b0;
  assign perr          = 1'b0;
`endif

  always_comb begin
    uaddr_d      = run ? addr : uaddr_q;
    ctrl_valid_d = run ? 1'b1 : ctrl_valid_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      uaddr_q      <= '0;
      ctrl_valid_q <= 1'b0;
    end else begin
      uaddr_q      <= uaddr_d;
      ctrl_valid_q <= ctrl_valid_d;
    end
  end

  // ctrl_valid_q remembers that the MIR holds a real word; stalls only mask it.
  always_comb begin
    seq_active = run;
    ctrl_valid = ctrl_valid_q && run;
    ctrl       = ctrl_valid ? mir.ctrl : '0;
    seq_din    = mir.offset;
    seq_op     = OP_NEXT;
    if (!halt && cond_test(mir.csel, mir.cinv, cond)) begin
      seq_op = mir.op;
    end
  end

endmodule

// File: tb/tb_microcode_fetch.sv
// Directed scoreboard bench for microcode_fetch; parity expectations follow UCODE_PARITY_EN.
module tb_microcode_fetch;

  logic        clock;
  logic        reset;
  logic [11:0] addr;
  logic [6:0]  cond;
  logic        stall;
  logic        load_en;
  logic [11:0] load_addr;
  logic [47:0] load_data;
  logic [1:0]  seq_op;
  logic [11:0] seq_din;
  logic        seq_active;
  logic [28:0] ctrl;
  logic        ctrl_valid;
  logic [11:0] uaddr_q;
  logic        perr;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [1:0]  op;
    logic [11:0] din;
    logic        sa;
    logic [28:0] ctrl;
    logic        cv;
    logic [11:0] ua;
    logic        perr;
  } exp_t;

  exp_t sb[$];

  microcode_fetch dut (
    .clock      (clock),
    .reset      (reset),
    .addr       (addr),
    .cond       (cond),
    .stall      (stall),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .seq_op     (seq_op),
    .seq_din    (seq_din),
    .seq_active (seq_active),
    .ctrl       (ctrl),
    .ctrl_valid (ctrl_valid),
    .uaddr_q    (uaddr_q),
    .perr       (perr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  // Builds a microword with the parity bit chosen so all 48 bits have even parity.
  function automatic logic [47:0] mk(input logic [1:0] op, input logic [2:0] csel,
                                     input logic cinv, input logic [11:0] off,
                                     input logic [28:0] c);
    logic [46:0] body;
    body = {op, csel, cinv, off, c};
    return {^body, body};
  endfunction

  task automatic check(input string tag, input string field,
                       input logic [47:0] obs, input logic [47:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, then compare either
  // #1 after the next rising edge or (do_edge=0) #1 after the input change.
  task automatic step(input string tag, input bit do_edge,
                      input logic rst, input logic stl, input logic le,
                      input logic [11:0] la, input logic [47:0] ld,
                      input logic [11:0] a, input logic [6:0] c,
                      input logic [1:0] e_op, input logic [11:0] e_din,
                      input logic e_sa, input logic [28:0] e_ctrl,
                      input logic e_cv, input logic [11:0] e_ua, input logic e_perr);
    exp_t e;
    reset = rst; stall = stl; load_en = le; load_addr = la; load_data = ld;
    addr = a; cond = c;
    e.tag = tag; e.op = e_op; e.din = e_din; e.sa = e_sa; e.ctrl = e_ctrl;
    e.cv = e_cv; e.ua = e_ua; e.perr = e_perr;
    sb.push_back(e);
    if (do_edge) begin
      @(posedge clock);
      #1;
    end else begin
      #1;
    end
    e = sb.pop_front();
    check(e.tag, "seq_op",     48'(seq_op),     48'(e.op));
    check(e.tag, "seq_din",    48'(seq_din),    48'(e.din));
    check(e.tag, "seq_active", 48'(seq_active), 48'(e.sa));
    check(e.tag, "ctrl",       48'(ctrl),       48'(e.ctrl));
    check(e.tag, "ctrl_valid", 48'(ctrl_valid), 48'(e.cv));
    check(e.tag, "uaddr_q",    48'(uaddr_q),    48'(e.ua));
    check(e.tag, "perr",       48'(perr),       48'(e.perr));
    $display("step %-12s op=%0d din=%03h act=%0b ctrl=%08h cv=%0b ua=%03h perr=%0b",
             e.tag, seq_op, seq_din, seq_active, ctrl, ctrl_valid, uaddr_q, perr);
  endtask

  logic [47:0] w0, w1, w2, w3, w4, wa, wb, wbad, wz;

  initial begin
    w0   = mk(2'd1, 3'd0, 1'b0, 12'h005, 29'h00000AA);
    w1   = mk(2'd2, 3'd3, 1'b0, 12'h020, 29'h0000111);
    w2   = mk(2'd2, 3'd3, 1'b1, 12'h030, 29'h0000222);
    w3   = mk(2'd3, 3'd7, 1'b0, 12'h000, 29'h0000333);
    w4   = mk(2'd1, 3'd0, 1'b1, 12'h044, 29'h0000444);
    wa   = mk(2'd0, 3'd0, 1'b0, 12'h0FF, 29'h1234567);
    wb   = mk(2'd1, 3'd0, 1'b0, 12'h077, 29'h0BBBBBB);
    wz   = mk(2'd1, 3'd0, 1'b0, 12'h03F, 29'h000003F);
    wbad = mk(2'd1, 3'd0, 1'b0, 12'h007, 29'h0000777);
    wbad[3] = ~wbad[3];

    reset = 1'b1; stall = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    addr = '0; cond = '0;

    //   tag            edge rst stl le la      ld    a       c      | op  din     sa  ctrl          cv  ua      perr
    step("rst_stall",    1, 1, 1, 0, 12'h0,  '0,   12'h0,  7'h00, 2'd0, 12'h000, 0, 29'h0,        0, 12'h000, 0);
    step("rst_run",      1, 1, 0, 0, 12'h0,  '0,   12'h0,  7'h00, 2'd0, 12'h000, 1, 29'h0,        0, 12'h000, 0);
    step("ld0",          1, 0, 1, 1, 12'h0,  w0,   12'h0,  7'h00, 2'd0, 12'h000, 0, 29'h0,        0, 12'h000, 0);
    step("ld1",          1, 0, 1, 1, 12'h1,  w1,   12'h0,  7'h00, 2'd0, 12'h000, 0, 29'h0,        0, 12'h000, 0);
    step("ld2",          1, 0, 1, 1, 12'h2,  w2,   12'h0,  7'h00, 2'd0, 12'h000, 0, 29'h0,        0, 12'h000, 0);
    step("ld3",          1, 0, 1, 1, 12'h3,  w3,   12'h0,  7'h00, 2'd0, 12'h000, 0, 29'h0,        0, 12'h000, 0);
    step("ld4",          1, 0, 1, 1, 12'h4,  w4,   12'h0,  7'h00, 2'd0, 12'h000, 0, 29'h0,        0, 12'h000, 0);
    step("ld10",         1, 0, 1, 1, 12'h10, wa,   12'h0,  7'h00, 2'd0, 12'h000, 0, 29'h0,        0, 12'h000, 0);
    step("ld7",          1, 0, 1, 1, 12'h7,  wbad, 12'h0,  7'h00, 2'd0, 12'h000, 0, 29'h0,        0, 12'h000, 0);
    step("rst_again",    1, 1, 0, 0, 12'h0,  '0,   12'h0,  7'h00, 2'd0, 12'h000, 1, 29'h0,        0, 12'h000, 0);
    step("jump0",        1, 0, 0, 0, 12'h0,  '0,   12'h0,  7'h00, 2'd1, 12'h005, 1, 29'h00000AA,  1, 12'h000, 0);
    step("call_c0",      1, 0, 0, 0, 12'h0,  '0,   12'h1,  7'h00, 2'd0, 12'h020, 1, 29'h0000111,  1, 12'h001, 0);
    step("stall_c1",     1, 0, 1, 0, 12'h0,  '0,   12'h2,  7'h04, 2'd2, 12'h020, 0, 29'h0,        0, 12'h001, 0);
    step("stall_c0",     1, 0, 1, 0, 12'h0,  '0,   12'h2,  7'h00, 2'd0, 12'h020, 0, 29'h0,        0, 12'h001, 0);
    step("stall_c1b",    1, 0, 1, 0, 12'h0,  '0,   12'h2,  7'h04, 2'd2, 12'h020, 0, 29'h0,        0, 12'h001, 0);
    step("release",      0, 0, 0, 0, 12'h0,  '0,   12'h2,  7'h04, 2'd2, 12'h020, 1, 29'h0000111,  1, 12'h001, 0);
    step("calli_c0",     1, 0, 0, 0, 12'h0,  '0,   12'h2,  7'h00, 2'd2, 12'h030, 1, 29'h0000222,  1, 12'h002, 0);
    step("calli_c1",     0, 0, 0, 0, 12'h0,  '0,   12'h2,  7'h04, 2'd0, 12'h030, 1, 29'h0000222,  1, 12'h002, 0);
    step("ret_c6",       1, 0, 0, 0, 12'h0,  '0,   12'h3,  7'h40, 2'd3, 12'h000, 1, 29'h0000333,  1, 12'h003, 0);
    step("ret_c0",       0, 0, 0, 0, 12'h0,  '0,   12'h3,  7'h00, 2'd0, 12'h000, 1, 29'h0000333,  1, 12'h003, 0);
    step("jump_inv",     1, 0, 0, 0, 12'h0,  '0,   12'h4,  7'h00, 2'd0, 12'h044, 1, 29'h0000444,  1, 12'h004, 0);
    step("read_first",   1, 0, 0, 1, 12'h10, wb,   12'h10, 7'h00, 2'd0, 12'h0FF, 1, 29'h1234567,  1, 12'h010, 0);
    step("new_word",     1, 0, 0, 0, 12'h0,  '0,   12'h10, 7'h00, 2'd1, 12'h077, 1, 29'h0BBBBBB,  1, 12'h010, 0);
`ifdef UCODE_PARITY_EN
    step("par_bad",      1, 0, 0, 0, 12'h0,  '0,   12'h7,  7'h00, 2'd0, 12'h007, 0, 29'h0,        0, 12'h007, 1);
    step("par_hold",     1, 0, 0, 0, 12'h0,  '0,   12'h0,  7'h00, 2'd0, 12'h007, 0, 29'h0,        0, 12'h007, 1);
`else
    step("par_bad",      1, 0, 0, 0, 12'h0,  '0,   12'h7,  7'h00, 2'd1, 12'h007, 1, 29'h000077F,  1, 12'h007, 0);
    step("par_hold",     1, 0, 0, 0, 12'h0,  '0,   12'h0,  7'h00, 2'd1, 12'h005, 1, 29'h00000AA,  1, 12'h000, 0);
`endif
    step("rst_midrun",   1, 1, 0, 0, 12'h0,  '0,   12'h1,  7'h00, 2'd0, 12'h000, 1, 29'h0,        0, 12'h000, 0);
    step("rst_stall_ld", 1, 1, 1, 1, 12'h0,  wz,   12'h0,  7'h00, 2'd0, 12'h000, 0, 29'h0,        0, 12'h000, 0);
    step("post_rst",     1, 0, 0, 0, 12'h0,  '0,   12'h0,  7'h00, 2'd1, 12'h005, 1, 29'h00000AA,  1, 12'h000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
